// File: rtl/bj_pkg.sv
// rtl/bj_pkg.sv - shared blackjack constants, card-shoe state encoding and rank-to-value mapping
package bj_pkg;

  localparam int         DECK_SIZE = 52;
  localparam logic [3:0] RANK_ACE  = 4'd1;
  localparam logic [3:0] RANK_KING = 4'd13;
  localparam int         VALUE_W   = 4;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SEEK    = 2'd1,
    S_PROBE   = 2'd2,
    S_DELIVER = 2'd3
  } shoe_state_t;

  // Blackjack value of a rank: ace counts 1 here, faces count 10.
  function automatic logic [VALUE_W-1:0] rank_to_value(input logic [3:0] rank);
    rank_to_value = (rank > 4'd10) ? 4'(10) : rank;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// rtl/lfsr16.sv - 16-bit Galois LFSR, x^16+x^14+x^13+x^11+1
// Ports: clk, resetn (async active-low), en (advance), lfsr (current state).
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        en,
  output logic [15:0] lfsr
);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lfsr <= SEED;
    end else if (en) begin
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end
  end

endmodule

// File: rtl/card_shoe.sv
// rtl/card_shoe.sv - 52-card shoe dealing one random undealt card per request
// Ports: CLOCK_50, resetn (async active-low); req (level), shuffle (pulse) in;
// card_valid pulse with card_rank/card_suit/card_value, cards_left, deck_empty,
// req_err pulse (request on empty deck) and busy out.
module card_shoe
  import bj_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic               CLOCK_50,
  input  logic               resetn,
  input  logic               req,
  input  logic               shuffle,
  output logic               card_valid,
  output logic [3:0]         card_rank,
  output logic [1:0]         card_suit,
  output logic [VALUE_W-1:0] card_value,
  output logic [5:0]         cards_left,
  output logic               deck_empty,
  output logic               req_err,
  output logic               busy
);

  shoe_state_t state, state_nxt;
  logic [15:0] lfsr;
  logic [63:0] dealt;        // indexed by {suit, rank}; ranks 0, 14, 15 unused
  logic [1:0]  cand_suit;
  logic [3:0]  cand_rank;
  logic [3:0]  raw_rank;
  logic [3:0]  new_rank;
  logic [5:0]  probe_idx;
  logic        slot_taken;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk    (CLOCK_50),
    .resetn (resetn),
    .en     (1'b1),
    .lfsr   (lfsr)
  );

  // Fold 0..15 onto 0..12, then shift to ranks 1..13.
  assign raw_rank   = lfsr[3:0];
  assign new_rank   = ((raw_rank >= 4'd13) ? (raw_rank - 4'd13) : raw_rank) + 4'd1;
  assign probe_idx  = {cand_suit, cand_rank};
  assign slot_taken = dealt[probe_idx];

  assign deck_empty = (cards_left == 6'd0);
  assign busy       = (state != S_IDLE);
  // A shuffle landing on the delivery cycle cancels the card.
  assign card_valid = (state == S_DELIVER) && !shuffle;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // SEEK is a fixed settle cycle between capture and the first probe.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (!shuffle && req && !deck_empty) state_nxt = S_SEEK;
      S_SEEK:    state_nxt = shuffle ? S_IDLE : S_PROBE;
      S_PROBE:   if (shuffle) state_nxt = S_IDLE;
                 else if (!slot_taken) state_nxt = S_DELIVER;
      S_DELIVER: state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      dealt      <= '0;
      cards_left <= 6'(DECK_SIZE);
      card_rank  <= '0;
      card_suit  <= '0;
      card_value <= '0;
      req_err    <= 1'b0;
      cand_suit  <= '0;
      cand_rank  <= '0;
    end else begin
      req_err <= 1'b0;
      if (shuffle) begin
        // Shuffle wins in every state and drops any card in flight.
        dealt      <= '0;
        cards_left <= 6'(DECK_SIZE);
        card_rank  <= '0;
        card_suit  <= '0;
        card_value <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (req) begin
              if (deck_empty) begin
                req_err <= 1'b1;
              end else begin
                cand_suit <= lfsr[5:4];
                cand_rank <= new_rank;
              end
            end
          end
          S_PROBE: begin
            if (!slot_taken) begin
              dealt[probe_idx] <= 1'b1;
              cards_left       <= cards_left - 6'd1;
              card_rank        <= cand_rank;
              card_suit        <= cand_suit;
              card_value       <= rank_to_value(cand_rank);
            end else if (cand_rank == RANK_KING) begin
              // Walk on to the ace of the next suit; the deck is non-empty,
              // so this terminates within 51 steps.
              cand_rank <= RANK_ACE;
              cand_suit <= cand_suit + 2'd1;
            end else begin
              cand_rank <= cand_rank + 4'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
